// File: rtl/connect4_turn_ctrl.sv
// Connect Four turn controller: owns the board and the column fill counts,
// alternates turns between the human button and the minimax engine, commits
// each drop and runs a four-direction win check through the new stone.
module connect4_turn_ctrl #(
  parameter int COLS = 7,
  parameter int ROWS = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sw,
  input  logic                     new_game,
  input  logic                     btn_drop,
  input  logic [2:0]               col_sel,
  input  logic                     ai_move,
  input  logic [6:0]               ai_opt,
  output logic [2*COLS*ROWS-1:0]   grid,
  output logic [3*COLS-1:0]        column_counts,
  output logic                     player,
  output logic                     game_over,
  output logic [1:0]               winner,
  output logic                     illegal,
  output logic                     ai_err
);

  localparam int CELLS = COLS * ROWS;
  localparam int GW    = 2 * CELLS;
  localparam int CW    = 3 * COLS;
  localparam int RW    = 2 * COLS;
  localparam int GIW   = $clog2(GW);
  localparam int CIW   = $clog2(CW);
  localparam int MW    = $clog2(CELLS + 1);

  typedef enum logic [2:0] {
    HUMAN_WAIT,
    AI_WAIT,
    PLACE,
    CHECK,
    OVER
  } state_t;

  state_t          state_q, state_n;
  logic [GW-1:0]   grid_n;
  logic [CW-1:0]   counts_n;
  logic            player_n, game_over_n, illegal_n, ai_err_n;
  logic [1:0]      winner_n;
  logic [MW-1:0]   moves_q, moves_n;
  logic [2:0]      col_q, col_n, row_q, row_n;
  logic [1:0]      owner_q, owner_n;
  logic [1:0]      dir_q, dir_n;
  logic            win_q, win_n, win_now;
  int              place_idx;

  // Run-length scratch for the line through the most recent stone
  int              dc, dr, cc, rr, run;
  logic            go_pos, go_neg, line_win;

  // Engine move decode scratch
  int              ai_m, ai_c, ai_r;
  logic            ai_valid;
  logic [2:0]      fb_col;

  // Two-bit cell content at column c, row r (row 0 is the bottom)
  function automatic logic [1:0] cell_at(input logic [GW-1:0] g, input int c, input int r);
    int idx;
    idx = (RW - 1) - 2 * c + RW * r;
    return g[GIW'(idx) -: 2];
  endfunction

  // Number of stones currently stacked in column c
  function automatic logic [2:0] count_at(input logic [CW-1:0] counts, input int c);
    return counts[CIW'(3 * c + 2) -: 3];
  endfunction

  // Length of the owner's run through (col,row) along the direction under check
  always_comb begin
    dc     = 0;
    dr     = 0;
    cc     = 0;
    rr     = 0;
    run    = 1;
    go_pos = 1'b1;
    go_neg = 1'b1;
    case (dir_q)
      2'd0:    begin dc = 1; dr = 0;  end
      2'd1:    begin dc = 0; dr = 1;  end
      2'd2:    begin dc = 1; dr = 1;  end
      default: begin dc = 1; dr = -1; end
    endcase
    for (int k = 1; k <= 3; k++) begin
      cc = int'(col_q) + k * dc;
      rr = int'(row_q) + k * dr;
      if (go_pos && cc >= 0 && cc < COLS && rr >= 0 && rr < ROWS &&
          cell_at(grid, cc, rr) == owner_q)
        run = run + 1;
      else
        go_pos = 1'b0;
    end
    for (int k = 1; k <= 3; k++) begin
      cc = int'(col_q) - k * dc;
      rr = int'(row_q) - k * dr;
      if (go_neg && cc >= 0 && cc < COLS && rr >= 0 && rr < ROWS &&
          cell_at(grid, cc, rr) == owner_q)
        run = run + 1;
      else
        go_neg = 1'b0;
    end
    line_win = (run >= 4);
  end

  // Decode the engine's high-bit cell index and find the fallback column
  always_comb begin
    ai_m     = int'(ai_opt) % RW;
    ai_c     = ((RW - 1) - ai_m) / 2;
    ai_r     = int'(ai_opt) / RW;
    ai_valid = ai_opt[0] && (int'(ai_opt) < GW) && (ai_c < COLS) &&
               (ai_r == int'(count_at(column_counts, ai_c)));
    fb_col   = 3'd0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (count_at(column_counts, c) != 3'(ROWS))
        fb_col = 3'(c);
    end
  end

  // Next-state and next-output logic for the turn FSM and board datapath
  always_comb begin
    state_n     = state_q;
    grid_n      = grid;
    counts_n    = column_counts;
    player_n    = player;
    game_over_n = game_over;
    winner_n    = winner;
    illegal_n   = 1'b0;
    ai_err_n    = 1'b0;
    moves_n     = moves_q;
    col_n       = col_q;
    row_n       = row_q;
    owner_n     = owner_q;
    dir_n       = dir_q;
    win_n       = win_q;
    win_now     = win_q | line_win;
    place_idx   = (RW - 1) - 2 * int'(col_q) + RW * int'(row_q);

    if (new_game) begin
      state_n     = HUMAN_WAIT;
      grid_n      = '0;
      counts_n    = '0;
      player_n    = 1'b0;
      game_over_n = 1'b0;
      winner_n    = 2'b00;
      moves_n     = '0;
      col_n       = 3'd0;
      row_n       = 3'd0;
      owner_n     = 2'b00;
      dir_n       = 2'd0;
      win_n       = 1'b0;
    end else begin
      unique case (state_q)
        HUMAN_WAIT: begin
          if (sw && player) begin
            state_n = AI_WAIT;
          end else if (btn_drop) begin
            if (col_sel > 3'(COLS - 1) ||
                count_at(column_counts, int'(col_sel)) == 3'(ROWS)) begin
              illegal_n = 1'b1;
            end else begin
              col_n   = col_sel;
              row_n   = count_at(column_counts, int'(col_sel));
              owner_n = player ? 2'b10 : 2'b01;
              state_n = PLACE;
            end
          end
        end
        AI_WAIT: begin
          if (!sw) begin
            state_n = HUMAN_WAIT;
          end else if (ai_move) begin
            owner_n = 2'b10;
            state_n = PLACE;
            if (ai_valid) begin
              col_n = 3'(ai_c);
              row_n = 3'(ai_r);
            end else begin
              ai_err_n = 1'b1;
              col_n    = fb_col;
              row_n    = count_at(column_counts, int'(fb_col));
            end
          end
        end
        PLACE: begin
          grid_n[GIW'(place_idx) -: 2] = owner_q;
          counts_n[CIW'(3 * int'(col_q) + 2) -: 3] =
            count_at(column_counts, int'(col_q)) + 3'd1;
          moves_n = moves_q + MW'(1);
          dir_n   = 2'd0;
          win_n   = 1'b0;
          state_n = CHECK;
        end
        CHECK: begin
          win_n = win_now;
          dir_n = dir_q + 2'd1;
          if (dir_q == 2'd3) begin
            if (win_now) begin
              game_over_n = 1'b1;
              winner_n    = owner_q;
              state_n     = OVER;
            end else if (moves_q == MW'(CELLS)) begin
              game_over_n = 1'b1;
              winner_n    = 2'b11;
              state_n     = OVER;
            end else begin
              player_n = ~player;
              state_n  = (sw && !player) ? AI_WAIT : HUMAN_WAIT;
            end
          end
        end
        OVER: begin
          state_n = OVER;
        end
        default: begin
          state_n = HUMAN_WAIT;
        end
      endcase
    end
  end

  // State, board and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HUMAN_WAIT;
      grid          <= '0;
      column_counts <= '0;
      player        <= 1'b0;
      game_over     <= 1'b0;
      winner        <= 2'b00;
      illegal       <= 1'b0;
      ai_err        <= 1'b0;
      moves_q       <= '0;
      col_q         <= 3'd0;
      row_q         <= 3'd0;
      owner_q       <= 2'b00;
      dir_q         <= 2'd0;
      win_q         <= 1'b0;
    end else begin
      state_q       <= state_n;
      grid          <= grid_n;
      column_counts <= counts_n;
      player        <= player_n;
      game_over     <= game_over_n;
      winner        <= winner_n;
      illegal       <= illegal_n;
      ai_err        <= ai_err_n;
      moves_q       <= moves_n;
      col_q         <= col_n;
      row_q         <= row_n;
      owner_q       <= owner_n;
      dir_q         <= dir_n;
      win_q         <= win_n;
    end
  end

endmodule
